// File: rtl/spi_minion_if.sv
// rtl/spi_minion_if.sv - pin and stream bundle between an SPI master side and spi_minion
interface spi_minion_if #(
  parameter int nbits = 32
);
  logic             cs;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             recv_val;
  logic             recv_rdy;
  logic [nbits-1:0] recv_msg;
  logic             send_val;
  logic             send_rdy;
  logic [nbits-1:0] send_msg;
  logic             overflow;
  logic             underflow;

  modport master (
    output cs, sclk, mosi, recv_val, recv_msg, send_rdy,
    input  miso, recv_rdy, send_val, send_msg, overflow, underflow
  );

  modport slave (
    input  cs, sclk, mosi, recv_val, recv_msg, send_rdy,
    output miso, recv_rdy, send_val, send_msg, overflow, underflow
  );
endinterface

// File: rtl/spi_minion.sv
// rtl/spi_minion.sv - oversampling SPI mode 0 follower with val/rdy word streams
module spi_minion #(
  parameter int nbits = 32
) (
  input  logic         clk,
  input  logic         reset,
  spi_minion_if.slave  bus
);
  localparam int cw = $clog2(nbits + 1);
  localparam logic [cw-1:0] last_bit = cw'(nbits - 1);
  localparam logic [cw-1:0] full_cnt = cw'(nbits);

  typedef enum logic [1:0] {st_idle, st_shift, st_done} state_t;

  state_t state, state_nxt;

  logic cs_s1, cs_sync, cs_prev;
  logic sclk_s1, sclk_sync, sclk_prev;
  logic mosi_s1, mosi_sync;

  logic             full;
  logic [nbits-1:0] tx_buf;
  logic [nbits-1:0] tx_shift;
  logic [nbits-1:0] rx_shift;
  logic [cw-1:0]    bit_cnt;
  logic             send_val_q;
  logic [nbits-1:0] send_msg_q;
  logic             overflow_q;
  logic             underflow_q;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic start_frame, rx_bit, tx_bit, word_end, commit;
  logic [nbits-1:0] rx_word;

  // Two-flop synchronisers on the master pins, with a history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1     <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      sclk_s1   <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_s1     <= bus.cs;
      cs_sync   <= cs_s1;
      cs_prev   <= cs_sync;
      sclk_s1   <= bus.sclk;
      sclk_sync <= sclk_s1;
      sclk_prev <= sclk_sync;
      mosi_s1   <= bus.mosi;
      mosi_sync <= mosi_s1;
    end
  end

  assign cs_fall   = !cs_sync && cs_prev;
  assign cs_rise   = cs_sync && !cs_prev;
  assign sclk_rise = sclk_sync && !sclk_prev;
  assign sclk_fall = !sclk_sync && sclk_prev;

  assign rx_word = {rx_shift[nbits-2:0], mosi_sync};
  // A finished word is only accepted if the output slot is free or being emptied now
  assign commit  = word_end && (!send_val_q || bus.send_rdy);

  // Frame state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing: decides the next state and which datapath action fires this cycle
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    rx_bit      = 1'b0;
    tx_bit      = 1'b0;
    word_end    = 1'b0;
    case (state)
      st_idle: begin
        if (cs_fall) begin
          start_frame = 1'b1;
          state_nxt   = st_shift;
        end
      end
      st_shift: begin
        if (cs_rise) begin
          state_nxt = st_idle;
        end else if (sclk_rise) begin
          rx_bit = 1'b1;
          if (bit_cnt == last_bit) begin
            word_end  = 1'b1;
            state_nxt = st_done;
          end
        end else if (sclk_fall && bit_cnt != '0 && bit_cnt != full_cnt) begin
          tx_bit = 1'b1;
        end
      end
      st_done: begin
        if (cs_rise) begin
          state_nxt = st_idle;
        end
      end
      default: state_nxt = st_st_fix();
    endcase
  end

  function automatic state_t st_st_fix();
    return st_idle;
  endfunction

  // Transmit buffer: a frame start consumes it; a new word is accepted only when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full   <= 1'b0;
      tx_buf <= '0;
    end else if (start_frame && full) begin
      full <= 1'b0;
    end else if (bus.recv_val && !full) begin
      full   <= 1'b1;
      tx_buf <= bus.recv_msg;
    end
  end

  // Serial shifters and bit counter; miso changes on sclk falls after the first bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      if (start_frame) begin
        tx_shift <= full ? tx_buf : '0;
      end else if (tx_bit) begin
        tx_shift <= tx_shift << 1;
      end
      if (start_frame) begin
        bit_cnt <= '0;
      end else if (rx_bit) begin
        rx_shift <= rx_word;
        bit_cnt  <= bit_cnt + 1'b1;
      end
    end
  end

  // Output word slot and the one-cycle error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      send_val_q  <= 1'b0;
      send_msg_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (commit) begin
        send_val_q <= 1'b1;
        send_msg_q <= rx_word;
      end else if (send_val_q && bus.send_rdy) begin
        send_val_q <= 1'b0;
      end
      overflow_q  <= word_end && !commit;
      underflow_q <= start_frame && !full;
    end
  end

  assign bus.miso      = tx_shift[nbits-1];
  assign bus.recv_rdy  = !full;
  assign bus.send_val  = send_val_q;
  assign bus.send_msg  = send_msg_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: doc/spi_minion.md
# spi_minion

SPI follower (minion) that sits on the peripheral side of the SPI link, the other end of the team's SPI master. It oversamples the master's `cs`, `sclk` and `mosi` pins in the local clock domain and deserialises one `nbits`-bit word per chip-select frame onto a val/rdy output stream. In the same frame it serialises a word taken from a val/rdy input stream onto `miso`. The link is SPI mode 0, MSB first.

## Interface
Parameters:
- `nbits`, default 32: word width shifted per frame (≥ 2).

Ports:
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `cs`  in  1: chip select from master, active low, asynchronous to `clk`.
- `sclk`  in  1: serial clock from master, idle low, asynchronous.
- `mosi`  in  1: serial data from master, asynchronous.
- `miso`  out  1: serial data to master; equals `tx_shift[nbits-1]`.
- `recv_val`  in  1: word to transmit is valid.
- `recv_rdy`  out  1: transmit buffer empty.
- `recv_msg`  in  nbits: word to transmit on the next frame.
- `send_val`  out  1: received word valid.
- `send_rdy`  in  1: consumer accepts the received word.
- `send_msg`  out  nbits: received word.
- `overflow`  out  1: one-cycle pulse when a completed word is dropped.
- `underflow`  out  1: one-cycle pulse when a frame starts with an empty transmit buffer.

## Operation
- Input sync:
  - Each of `cs`, `sclk` and `mosi` passes through two flops, plus a third "prev" flop on `cs` and `sclk`.
  - Reset values: cs flops 1, sclk flops 0, mosi flops 0.
  - `sclk_rise` = sync & !prev; `sclk_fall` = !sync & prev. `cs_fall` and `cs_rise` are defined the same way.
- Transmit buffer:
  - One-entry register with a full flag. `recv_rdy` = !full.
  - A transfer occurs when `recv_val && recv_rdy`.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on `cs_fall`:
    - If the buffer is full, load `tx_shift` from it and clear full.
    - If the buffer is empty, load `tx_shift` with 0 and pulse `underflow`.
    - Clear the bit counter, then go to SHIFT.
  - SHIFT, on `sclk_rise`: `rx_shift <= {rx_shift[nbits-2:0], mosi_sync}`; counter++.
  - SHIFT, on `sclk_fall`: `tx_shift <= tx_shift << 1`, but only if counter ≠ 0 and counter ≠ nbits.
  - SHIFT, when the counter reaches nbits on a rise: go to DONE and commit the word.
    - Commit writes `{rx_shift[nbits-2:0], mosi_sync}` into `send_msg` and sets `send_val`, if `send_val` is low or `send_rdy` is high that cycle.
    - Otherwise the word is dropped and `overflow` pulses. `send_msg` keeps the old word.
  - DONE: all `sclk` edges are ignored. `cs_rise` → IDLE.
  - SHIFT, `cs_rise` before nbits bits: discard the partial word, no commit, → IDLE.
- Output buffer: `send_val` clears on `send_val && send_rdy` unless a commit happens in the same cycle. In that case it stays high with the new data.
- Simultaneous events:
  - A buffer fill (`recv_val`) in the same cycle as `cs_fall` with the buffer empty: the frame uses 0 and `underflow` pulses. The new word is stored for the next frame.
  - A word loaded during an active frame waits for the next `cs_fall`.
- Counter width: `$clog2(nbits+1)`; it never wraps.

## Timing
- Reset values:
  - `miso` 0, `recv_rdy` 1, `send_val` 0, `send_msg` 0.
  - `overflow` and `underflow` 0; FSM in IDLE; counters and shift registers 0.
- Detection latency: a raw pin edge is acted on at the 3rd `clk` rising edge after it, with +1 cycle uncertainty from asynchronous sampling.
- Frame latency:
  - MSB is on `miso` 3–4 clk after `cs` falls.
  - `send_val` rises 3–4 clk after the nbits-th `sclk` rising edge.
- `sclk` constraints:
  - Each high and low phase must be ≥ 4 clk periods.
  - `cs` low to first `sclk` rise ≥ 4 clk.
  - Violations are unsupported.
- Reset mid-frame:
  - Everything returns to reset values; both buffers are lost.
  - If `cs` is still low when reset releases, a `cs_fall` is detected and a frame starts (cs flops reset to 1).

## Test plan
- `nbits`=8, reset, then check idle outputs: `recv_rdy`=1, `send_val`=0, `miso`=0.
- Load `recv_msg`=0xA5. Master sends 0x3C in a full 8-bit frame → `miso` emits 1,0,1,0,0,1,0,1. `send_msg`=0x3C, `send_val`=1 within 4 clk of the 8th rise. No pulses.
- Hold `send_rdy`=0 and run two frames (0x11, 0x22) → `send_msg`=0x11 and `overflow` pulses once after frame 2. Raise `send_rdy` → `send_val` drops.
- Frame with an empty tx buffer → `underflow` pulses once, `miso` stays 0 for the whole frame, received word still delivered.
- `cs` rises after 5 bits, then a full frame of 0x81 → only 0x81 is delivered; the partial word is never seen.
- Assert `reset` after 4 bits of a frame, release with `cs` low, then clock 8 bits of 0xF0 → a new frame starts. `send_msg`=0xF0, `underflow` pulses.
